// File: rtl/types_amba_pkg.sv
// -----------------------------------------------------------------------------
// types_amba_pkg
// Shared AXI4 system-bus types used by the bus fabric and its buffers.
//   axi4_metadata_type   : address-channel payload (addr, len, size, burst, ...)
//   axi4_master_out_type : requests driven by a master (AW, W, AR + B/R ready)
//   axi4_master_in_type  : responses seen by a master (B, R + AW/W/AR ready)
//   axi4_slave_in_type   : same bundle as master_out, seen from the slave side
//   axi4_slave_out_type  : same bundle as master_in, driven by a slave
// -----------------------------------------------------------------------------
package types_amba_pkg;

  localparam int CFG_SYSBUS_ADDR_BITS  = 32;
  localparam int CFG_SYSBUS_DATA_BITS  = 64;
  localparam int CFG_SYSBUS_DATA_BYTES = 8;
  localparam int CFG_SYSBUS_ID_BITS    = 4;
  localparam int CFG_SYSBUS_USER_BITS  = 1;

  typedef struct packed {
    logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
    logic [7:0]                      len;
    logic [2:0]                      size;
    logic [1:0]                      burst;
    logic                            lock;
    logic [3:0]                      cache;
    logic [2:0]                      prot;
    logic [3:0]                      qos;
    logic [3:0]                      region;
  } axi4_metadata_type;

  typedef struct packed {
    logic                             aw_valid;
    axi4_metadata_type                aw_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
    logic                             w_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
    logic                             w_last;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
    logic [CFG_SYSBUS_USER_BITS-1:0]  w_user;
    logic                             b_ready;
    logic                             ar_valid;
    axi4_metadata_type                ar_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
    logic                             r_ready;
  } axi4_master_out_type;

  typedef struct packed {
    logic                            aw_ready;
    logic                            w_ready;
    logic                            b_valid;
    logic [1:0]                      b_resp;
    logic [CFG_SYSBUS_ID_BITS-1:0]   b_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] b_user;
    logic                            ar_ready;
    logic                            r_valid;
    logic [1:0]                      r_resp;
    logic [CFG_SYSBUS_DATA_BITS-1:0] r_data;
    logic                            r_last;
    logic [CFG_SYSBUS_ID_BITS-1:0]   r_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] r_user;
  } axi4_master_in_type;

  typedef axi4_master_out_type axi4_slave_in_type;
  typedef axi4_master_in_type  axi4_slave_out_type;

endpackage

// File: rtl/axi4_sync_buffer.sv
// -----------------------------------------------------------------------------
// axi4_sync_buffer
// Same-clock AXI4 buffer between an upstream slave port and a downstream
// master port. Each of the five channels has its own FIFO (depth 0 = wire),
// and two outstanding-transaction limiters throttle AW and AR acceptance.
//
// Ports:
//   i_clk             single clock for both ports
//   i_rst             asynchronous active-high reset
//   i_xslvi/o_xslvo   upstream requests / responses (slave side)
//   o_xmsto/i_xmsti   downstream requests / responses (master side)
//   o_wr_outstanding  accepted AW minus completed B (registered)
//   o_rd_outstanding  accepted AR minus completed R-last (registered)
//
// Handshake: on every channel a beat transfers on a rising edge where valid
// and ready are both 1. valid never depends on ready of the same channel;
// buffered-channel ready depends only on the registered fill count, bypass
// ready follows the far-side ready combinationally. All valids and readies
// are forced to 0 while i_rst is high.
// -----------------------------------------------------------------------------
module axi4_sync_buffer
  import types_amba_pkg::*;
#(
  parameter int AW_DEPTH           = 2,
  parameter int W_DEPTH            = 4,
  parameter int B_DEPTH            = 2,
  parameter int AR_DEPTH           = 2,
  parameter int R_DEPTH            = 4,
  parameter int MAX_WR_OUTSTANDING = 8,
  parameter int MAX_RD_OUTSTANDING = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  axi4_slave_in_type   i_xslvi,
  output axi4_slave_out_type  o_xslvo,
  output axi4_master_out_type o_xmsto,
  input  axi4_master_in_type  i_xmsti,
  output logic [7:0]          o_wr_outstanding,
  output logic [7:0]          o_rd_outstanding
);

  localparam int ID_W   = CFG_SYSBUS_ID_BITS;
  localparam int USER_W = CFG_SYSBUS_USER_BITS;
  localparam int DATA_W = CFG_SYSBUS_DATA_BITS;
  localparam int ADDR_PW = ID_W + $bits(axi4_metadata_type) + USER_W;
  localparam int W_PW    = DATA_W + CFG_SYSBUS_DATA_BYTES + 1 + USER_W;
  localparam int B_PW    = ID_W + 2 + USER_W;
  localparam int R_PW    = ID_W + DATA_W + 2 + 1 + USER_W;

  // Channel-side views: "in" faces the producer, "out" faces the consumer.
  logic              aw_in_valid, aw_in_ready, aw_out_valid, aw_out_ready;
  logic [ADDR_PW-1:0] aw_in_data, aw_out_data;
  logic              w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [W_PW-1:0]   w_in_data, w_out_data;
  logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [B_PW-1:0]   b_in_data, b_out_data;
  logic              ar_in_valid, ar_in_ready, ar_out_valid, ar_out_ready;
  logic [ADDR_PW-1:0] ar_in_data, ar_out_data;
  logic              r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [R_PW-1:0]   r_in_data, r_out_data;

  // Limiter state
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic       wr_full, rd_full;
  logic       aw_slv_ready, ar_slv_ready;
  logic       aw_hs, b_hs, ar_hs, r_last_hs;

  // ---------------------------------------------------------------------------
  // Limiters: when the limit is reached the AW/AR channel is cut on both
  // valid (no FIFO push) and ready (upstream sees a stall).
  // ---------------------------------------------------------------------------
  assign wr_full = (MAX_WR_OUTSTANDING != 0) && (wr_cnt_q == 8'(MAX_WR_OUTSTANDING));
  assign rd_full = (MAX_RD_OUTSTANDING != 0) && (rd_cnt_q == 8'(MAX_RD_OUTSTANDING));

  assign aw_slv_ready = aw_in_ready & ~wr_full;
  assign ar_slv_ready = ar_in_ready & ~rd_full;

  assign aw_hs     = i_xslvi.aw_valid & aw_slv_ready;
  assign b_hs      = b_out_valid & i_xslvi.b_ready;
  assign ar_hs     = i_xslvi.ar_valid & ar_slv_ready;
  // Only the final R beat of a burst retires a read.
  assign r_last_hs = r_out_valid & i_xslvi.r_ready & r_out_data[USER_W];

  // Saturating up/down step; a decrement at zero is ignored.
  function automatic logic [7:0] cnt_step(input logic [7:0] cnt,
                                          input logic       inc,
                                          input logic       dec);
    logic [7:0] res;
    res = cnt;
    if (inc && !dec && (cnt != 8'hFF)) begin
      res = cnt + 8'd1;
    end else if (dec && !inc && (cnt != 8'h00)) begin
      res = cnt - 8'd1;
    end
    return res;
  endfunction

  always_comb begin
    wr_cnt_d = cnt_step(wr_cnt_q, aw_hs, b_hs);
    rd_cnt_d = cnt_step(rd_cnt_q, ar_hs, r_last_hs);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_cnt_q <= 8'd0;
      rd_cnt_q <= 8'd0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign o_wr_outstanding = wr_cnt_q;
  assign o_rd_outstanding = rd_cnt_q;

  // ---------------------------------------------------------------------------
  // Channel inputs
  // ---------------------------------------------------------------------------
  assign aw_in_valid  = i_xslvi.aw_valid & ~wr_full;
  assign aw_in_data   = {i_xslvi.aw_id, i_xslvi.aw_bits, i_xslvi.aw_user};
  assign aw_out_ready = i_xmsti.aw_ready;

  assign w_in_valid   = i_xslvi.w_valid;
  assign w_in_data    = {i_xslvi.w_data, i_xslvi.w_strb, i_xslvi.w_last, i_xslvi.w_user};
  assign w_out_ready  = i_xmsti.w_ready;

  assign b_in_valid   = i_xmsti.b_valid;
  assign b_in_data    = {i_xmsti.b_id, i_xmsti.b_resp, i_xmsti.b_user};
  assign b_out_ready  = i_xslvi.b_ready;

  assign ar_in_valid  = i_xslvi.ar_valid & ~rd_full;
  assign ar_in_data   = {i_xslvi.ar_id, i_xslvi.ar_bits, i_xslvi.ar_user};
  assign ar_out_ready = i_xmsti.ar_ready;

  assign r_in_valid   = i_xmsti.r_valid;
  assign r_in_data    = {i_xmsti.r_id, i_xmsti.r_data, i_xmsti.r_resp,
                         i_xmsti.r_last, i_xmsti.r_user};
  assign r_out_ready  = i_xslvi.r_ready;

  // ---------------------------------------------------------------------------
  // Per-channel storage: FIFO or gated wire
  // ---------------------------------------------------------------------------
  if (AW_DEPTH == 0) begin : g_aw_bypass
    assign aw_out_valid = aw_in_valid & ~i_rst;
    assign aw_in_ready  = aw_out_ready & ~i_rst;
    assign aw_out_data  = aw_in_data;
  end else begin : g_aw_fifo
    axi4_sync_buffer_fifo #(.DEPTH(AW_DEPTH), .WIDTH(ADDR_PW)) u_fifo (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_in_valid(aw_in_valid), .o_in_ready(aw_in_ready), .i_in_data(aw_in_data),
      .o_out_valid(aw_out_valid), .i_out_ready(aw_out_ready), .o_out_data(aw_out_data)
    );
  end

  if (W_DEPTH == 0) begin : g_w_bypass
    assign w_out_valid = w_in_valid & ~i_rst;
    assign w_in_ready  = w_out_ready & ~i_rst;
    assign w_out_data  = w_in_data;
  end else begin : g_w_fifo
    axi4_sync_buffer_fifo #(.DEPTH(W_DEPTH), .WIDTH(W_PW)) u_fifo (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_in_valid(w_in_valid), .o_in_ready(w_in_ready), .i_in_data(w_in_data),
      .o_out_valid(w_out_valid), .i_out_ready(w_out_ready), .o_out_data(w_out_data)
    );
  end

  if (B_DEPTH == 0) begin : g_b_bypass
    assign b_out_valid = b_in_valid & ~i_rst;
    assign b_in_ready  = b_out_ready & ~i_rst;
    assign b_out_data  = b_in_data;
  end else begin : g_b_fifo
    axi4_sync_buffer_fifo #(.DEPTH(B_DEPTH), .WIDTH(B_PW)) u_fifo (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
      .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data)
    );
  end

  if (AR_DEPTH == 0) begin : g_ar_bypass
    assign ar_out_valid = ar_in_valid & ~i_rst;
    assign ar_in_ready  = ar_out_ready & ~i_rst;
    assign ar_out_data  = ar_in_data;
  end else begin : g_ar_fifo
    axi4_sync_buffer_fifo #(.DEPTH(AR_DEPTH), .WIDTH(ADDR_PW)) u_fifo (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_in_valid(ar_in_valid), .o_in_ready(ar_in_ready), .i_in_data(ar_in_data),
      .o_out_valid(ar_out_valid), .i_out_ready(ar_out_ready), .o_out_data(ar_out_data)
    );
  end

  if (R_DEPTH == 0) begin : g_r_bypass
    assign r_out_valid = r_in_valid & ~i_rst;
    assign r_in_ready  = r_out_ready & ~i_rst;
    assign r_out_data  = r_in_data;
  end else begin : g_r_fifo
    axi4_sync_buffer_fifo #(.DEPTH(R_DEPTH), .WIDTH(R_PW)) u_fifo (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_in_valid(r_in_valid), .o_in_ready(r_in_ready), .i_in_data(r_in_data),
      .o_out_valid(r_out_valid), .i_out_ready(r_out_ready), .o_out_data(r_out_data)
    );
  end

  // ---------------------------------------------------------------------------
  // Output bundles
  // ---------------------------------------------------------------------------
  always_comb begin
    o_xmsto = '0;
    o_xmsto.aw_valid = aw_out_valid;
    {o_xmsto.aw_id, o_xmsto.aw_bits, o_xmsto.aw_user} = aw_out_data;
    o_xmsto.w_valid  = w_out_valid;
    {o_xmsto.w_data, o_xmsto.w_strb, o_xmsto.w_last, o_xmsto.w_user} = w_out_data;
    o_xmsto.b_ready  = b_in_ready;
    o_xmsto.ar_valid = ar_out_valid;
    {o_xmsto.ar_id, o_xmsto.ar_bits, o_xmsto.ar_user} = ar_out_data;
    o_xmsto.r_ready  = r_in_ready;
  end

  always_comb begin
    o_xslvo = '0;
    o_xslvo.aw_ready = aw_slv_ready;
    o_xslvo.w_ready  = w_in_ready;
    o_xslvo.b_valid  = b_out_valid;
    {o_xslvo.b_id, o_xslvo.b_resp, o_xslvo.b_user} = b_out_data;
    o_xslvo.ar_ready = ar_slv_ready;
    o_xslvo.r_valid  = r_out_valid;
    {o_xslvo.r_id, o_xslvo.r_data, o_xslvo.r_resp, o_xslvo.r_last, o_xslvo.r_user} = r_out_data;
  end

endmodule

// -----------------------------------------------------------------------------
// axi4_sync_buffer_fifo
// Circular-buffer FIFO for one channel. DEPTH is a power of two (2..16).
//   i_in_valid/o_in_ready/i_in_data     producer side
//   o_out_valid/i_out_ready/o_out_data  consumer side
// Ready looks only at the registered count, so a full FIFO refuses a push
// even in a cycle where it pops.
// -----------------------------------------------------------------------------
module axi4_sync_buffer_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push, pop;

  assign o_in_ready  = ~i_rst & (count_q != FULL);
  assign o_out_valid = ~i_rst & (count_q != '0);
  assign o_out_data  = mem_q[rd_ptr_q];

  assign push = i_in_valid & o_in_ready;
  assign pop  = o_out_valid & i_out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = i_in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: an empty count already hides stale entries.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_axi4_sync_buffer.sv
// Directed bench for axi4_sync_buffer: a buffered instance (MAX_RD=2) and an
// all-bypass instance (limits of 1). Inputs change and outputs are sampled
// in the low clock phase; handshakes happen on the following rising edge.
module tb_axi4_sync_buffer;
  import types_amba_pkg::*;

  logic clk;
  logic rst;

  axi4_slave_in_type   ai, bi;
  axi4_slave_out_type  ao, bso;
  axi4_master_out_type mo, bmo;
  axi4_master_in_type  mi, bmi;
  logic [7:0] a_wr_out, a_rd_out, b_wr_out, b_rd_out;

  int n_chk;
  int n_err;
  logic [64:0] exp_q[$];

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi4_sync_buffer #(
    .AW_DEPTH(2), .W_DEPTH(4), .B_DEPTH(2), .AR_DEPTH(2), .R_DEPTH(4),
    .MAX_WR_OUTSTANDING(8), .MAX_RD_OUTSTANDING(2)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_xslvi(ai), .o_xslvo(ao), .o_xmsto(mo), .i_xmsti(mi),
    .o_wr_outstanding(a_wr_out), .o_rd_outstanding(a_rd_out)
  );

  axi4_sync_buffer #(
    .AW_DEPTH(0), .W_DEPTH(0), .B_DEPTH(0), .AR_DEPTH(0), .R_DEPTH(0),
    .MAX_WR_OUTSTANDING(1), .MAX_RD_OUTSTANDING(1)
  ) dut_byp (
    .i_clk(clk), .i_rst(rst),
    .i_xslvi(bi), .o_xslvo(bso), .o_xmsto(bmo), .i_xmsti(bmi),
    .o_wr_outstanding(b_wr_out), .o_rd_outstanding(b_rd_out)
  );

  // ---------------------------------------------------------------- checker
  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] wr_beat(input int i);
    return 64'h1111_0000_0000_0000 + 64'(i);
  endfunction

  function automatic logic [63:0] bp_beat(input int i);
    return 64'h0000_00A0 + 64'(i);
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic drive_w(input logic [63:0] data, input logic last);
    ai.w_valid = 1'b1;
    ai.w_data  = data;
    ai.w_strb  = 8'hFF;
    ai.w_last  = last;
  endtask

  // ---------------------------------------------------------------- stimulus
  int idx;
  int popped;
  int wcnt, rcnt;
  logic exp_aw_rdy, exp_ar_rdy, aw_hs, b_hs, ar_hs, r_hs;
  logic [64:0] exp_beat;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    ai = '0; mi = '0; bi = '0; bmi = '0;

    // Reset values, with traffic offered on both sides
    @(negedge clk);
    ai.aw_valid = 1'b1; mi.aw_ready = 1'b1; mi.b_valid = 1'b1;
    bi.aw_valid = 1'b1; bmi.aw_ready = 1'b1; bmi.b_valid = 1'b1;
    #1;
    chk("rst_aw_ready", ao.aw_ready, 1'b0);
    chk("rst_w_ready", ao.w_ready, 1'b0);
    chk("rst_ar_ready", ao.ar_ready, 1'b0);
    chk("rst_b_ready_m", mo.b_ready, 1'b0);
    chk("rst_m_aw_valid", mo.aw_valid, 1'b0);
    chk("rst_s_b_valid", ao.b_valid, 1'b0);
    chk("rst_wr_out", a_wr_out, 8'd0);
    chk("rst_byp_aw_valid", bmo.aw_valid, 1'b0);
    chk("rst_byp_aw_ready", bso.aw_ready, 1'b0);
    chk("rst_byp_b_valid", bso.b_valid, 1'b0);

    @(negedge clk);
    ai = '0; mi = '0; bi = '0; bmi = '0;
    rst = 1'b0;
    mi.aw_ready = 1'b1; mi.w_ready = 1'b1; mi.ar_ready = 1'b1;
    #1;
    chk("post_rst_aw_ready", ao.aw_ready, 1'b1);
    chk("post_rst_w_ready", ao.w_ready, 1'b1);
    chk("post_rst_r_ready_m", mo.r_ready, 1'b1);

    // ---- Single write: AW len=3, 4 W beats, B id=5
    @(negedge clk);
    ai.aw_valid = 1'b1; ai.aw_id = 4'd3;
    ai.aw_bits.addr = 32'h0000_1000; ai.aw_bits.len = 8'd3;
    #1;
    chk("wr_aw_ready", ao.aw_ready, 1'b1);
    chk("wr_aw_not_yet", mo.aw_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ai.aw_valid = 1'b0;
      if (i < 4) drive_w(wr_beat(i), i == 3);
      else ai.w_valid = 1'b0;
      #1;
      if (i == 0) begin
        chk("wr_aw_valid", mo.aw_valid, 1'b1);
        chk("wr_aw_addr", mo.aw_bits.addr, 32'h0000_1000);
        chk("wr_aw_len", mo.aw_bits.len, 8'd3);
        chk("wr_aw_id", mo.aw_id, 4'd3);
        chk("wr_out_1", a_wr_out, 8'd1);
      end else begin
        chk("wr_w_valid", mo.w_valid, 1'b1);
        chk("wr_w_data", mo.w_data, wr_beat(i - 1));
        chk("wr_w_last", mo.w_last, i == 4);
      end
    end
    @(negedge clk);
    #1;
    chk("wr_w_drained", mo.w_valid, 1'b0);
    chk("wr_aw_drained", mo.aw_valid, 1'b0);

    @(negedge clk);
    mi.b_valid = 1'b1; mi.b_id = 4'd5; mi.b_resp = 2'd0;
    ai.b_ready = 1'b1;
    #1;
    chk("wr_b_not_yet", ao.b_valid, 1'b0);
    @(negedge clk);
    mi.b_valid = 1'b0;
    #1;
    chk("wr_b_valid", ao.b_valid, 1'b1);
    chk("wr_b_id", ao.b_id, 4'd5);
    chk("wr_out_still_1", a_wr_out, 8'd1);
    @(negedge clk);
    #1;
    chk("wr_out_0", a_wr_out, 8'd0);
    chk("wr_b_gone", ao.b_valid, 1'b0);

    // ---- Back-pressure fill of W FIFO (depth 4)
    mi.w_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive_w(bp_beat(idx), idx == 5);
      #1;
      chk("bp_w_ready", ao.w_ready, c < 4);
      if (c == 5) chk("bp_head_held", mo.w_data, bp_beat(0));
      if (ai.w_valid && ao.w_ready) begin
        exp_q.push_back({idx == 5, bp_beat(idx)});
        idx++;
      end
    end
    chk("bp_accepted", idx, 4);
    popped = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) mi.w_ready = 1'b1;
      if (idx < 6) drive_w(bp_beat(idx), idx == 5);
      else ai.w_valid = 1'b0;
      #1;
      if (c == 0) chk("full_pop_no_push", ao.w_ready, 1'b0);
      if (c == 1) chk("ready_after_pop", ao.w_ready, 1'b1);
      if (ai.w_valid && ao.w_ready) begin
        exp_q.push_back({idx == 5, bp_beat(idx)});
        idx++;
      end
      if (mo.w_valid && mi.w_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra_beat", 1'b1, 1'b0);
        end else begin
          exp_beat = exp_q.pop_front();
          chk("bp_order", {mo.w_last, mo.w_data}, exp_beat);
          popped++;
        end
      end
    end
    chk("bp_popped", popped, 6);

    // ---- Concurrent AW accept and B handshake
    @(negedge clk);
    ai.aw_valid = 1'b1; ai.aw_id = 4'd7;
    @(negedge clk);
    ai.aw_valid = 1'b0;
    mi.b_valid = 1'b1; mi.b_id = 4'd7; ai.b_ready = 1'b1;
    #1;
    chk("sim_wr_out_1", a_wr_out, 8'd1);
    @(negedge clk);
    mi.b_valid = 1'b0;
    ai.aw_valid = 1'b1; ai.aw_id = 4'd8;
    #1;
    chk("sim_b_valid", ao.b_valid, 1'b1);
    chk("sim_aw_ready", ao.aw_ready, 1'b1);
    @(negedge clk);
    ai.aw_valid = 1'b0;
    #1;
    chk("sim_wr_unchanged", a_wr_out, 8'd1);
    chk("sim_b_drained", ao.b_valid, 1'b0);

    // ---- Read limiter (MAX_RD_OUTSTANDING=2)
    ai.r_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ai.ar_valid = 1'b1; ai.ar_id = 4'(c + 1);
      #1;
      chk("lim_ar_ready", ao.ar_ready, c < 2);
      if (c > 0) chk("lim_m_ar_id", mo.ar_id, 4'(c));
    end
    chk("lim_rd_out_2", a_rd_out, 8'd2);
    @(negedge clk);
    mi.r_valid = 1'b1; mi.r_id = 4'd1; mi.r_last = 1'b0; mi.r_data = 64'hBEEF_0000;
    #1;
    chk("lim_stall_c3", ao.ar_ready, 1'b0);
    @(negedge clk);
    mi.r_last = 1'b1; mi.r_data = 64'hBEEF_0001;
    #1;
    chk("lim_r0_valid", ao.r_valid, 1'b1);
    chk("lim_r0_data", ao.r_data, 64'hBEEF_0000);
    chk("lim_stall_c4", ao.ar_ready, 1'b0);
    @(negedge clk);
    mi.r_valid = 1'b0;
    #1;
    chk("lim_r1_last", ao.r_last, 1'b1);
    chk("lim_nonlast_keeps", a_rd_out, 8'd2);
    chk("lim_stall_c5", ao.ar_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("lim_released", ao.ar_ready, 1'b1);
    chk("lim_rd_out_1", a_rd_out, 8'd1);
    @(negedge clk);
    ai.ar_valid = 1'b0;
    #1;
    chk("lim_rd_out_back_2", a_rd_out, 8'd2);
    chk("lim_m_ar_id3", mo.ar_id, 4'd3);

    // ---- Reset mid-burst: 3 R beats buffered, rd_cnt=2
    ai.r_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mi.r_valid = 1'b1; mi.r_id = 4'd2; mi.r_last = 1'b0;
      mi.r_data = 64'hDEAD_0000 + 64'(c);
    end
    @(negedge clk);
    mi.r_valid = 1'b0;
    #1;
    chk("mid_r_valid_pre", ao.r_valid, 1'b1);
    chk("mid_rd_out_pre", a_rd_out, 8'd2);
    rst = 1'b1;
    #1;
    chk("mid_r_valid_rst", ao.r_valid, 1'b0);
    chk("mid_rd_out_rst", a_rd_out, 8'd0);
    chk("mid_wr_out_rst", a_wr_out, 8'd0);
    chk("mid_ar_ready_rst", ao.ar_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ai.r_ready = 1'b1;
    #1;
    chk("mid_ar_ready_rel", ao.ar_ready, 1'b1);
    chk("mid_w_ready_rel", ao.w_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("mid_no_stale_r", ao.r_valid, 1'b0);
    end

    // ---- Bypass instance: same-cycle passthrough with limiters of 1
    ai = '0; mi = '0;
    wcnt = 0;
    rcnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bi.aw_valid = 1'($urandom_range(0, 1));
      bi.aw_bits.addr = $urandom;
      bi.aw_id = 4'($urandom_range(0, 15));
      bi.w_valid = 1'($urandom_range(0, 1));
      bi.w_data = {$urandom, $urandom};
      bi.b_ready = 1'($urandom_range(0, 1));
      bi.ar_valid = 1'($urandom_range(0, 1));
      bi.ar_bits.addr = $urandom;
      bi.r_ready = 1'($urandom_range(0, 1));
      bmi.aw_ready = 1'($urandom_range(0, 1));
      bmi.w_ready = 1'($urandom_range(0, 1));
      bmi.b_valid = 1'($urandom_range(0, 1));
      bmi.b_id = 4'($urandom_range(0, 15));
      bmi.ar_ready = 1'($urandom_range(0, 1));
      bmi.r_valid = 1'($urandom_range(0, 1));
      bmi.r_data = {$urandom, $urandom};
      bmi.r_last = 1'($urandom_range(0, 1));
      #1;
      exp_aw_rdy = bmi.aw_ready && (wcnt != 1);
      exp_ar_rdy = bmi.ar_ready && (rcnt != 1);
      chk("byp_aw_ready", bso.aw_ready, exp_aw_rdy);
      chk("byp_aw_valid", bmo.aw_valid, bi.aw_valid && (wcnt != 1));
      chk("byp_aw_addr", bmo.aw_bits.addr, bi.aw_bits.addr);
      chk("byp_aw_id", bmo.aw_id, bi.aw_id);
      chk("byp_w_valid", bmo.w_valid, bi.w_valid);
      chk("byp_w_ready", bso.w_ready, bmi.w_ready);
      chk("byp_w_data", bmo.w_data, bi.w_data);
      chk("byp_b_valid", bso.b_valid, bmi.b_valid);
      chk("byp_b_id", bso.b_id, bmi.b_id);
      chk("byp_b_ready", bmo.b_ready, bi.b_ready);
      chk("byp_ar_ready", bso.ar_ready, exp_ar_rdy);
      chk("byp_ar_valid", bmo.ar_valid, bi.ar_valid && (rcnt != 1));
      chk("byp_ar_addr", bmo.ar_bits.addr, bi.ar_bits.addr);
      chk("byp_r_data", bso.r_data, bmi.r_data);
      chk("byp_r_last", bso.r_last, bmi.r_last);
      chk("byp_wr_out", b_wr_out, 8'(wcnt));
      chk("byp_rd_out", b_rd_out, 8'(rcnt));
      aw_hs = bi.aw_valid && exp_aw_rdy;
      b_hs  = bmi.b_valid && bi.b_ready;
      ar_hs = bi.ar_valid && exp_ar_rdy;
      r_hs  = bmi.r_valid && bi.r_ready && bmi.r_last;
      if (aw_hs && !b_hs && wcnt != 255) wcnt++;
      else if (b_hs && !aw_hs && wcnt != 0) wcnt--;
      if (ar_hs && !r_hs && rcnt != 255) rcnt++;
      else if (r_hs && !ar_hs && rcnt != 0) rcnt--;
    end

    @(negedge clk);
    bi = '0; bmi = '0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
